buf_sched: RTL and testbench
============================

Name: buf_sched

Overview:
- Scheduler that sequences the ping-pong source and destination buffers around the MAC core.
- Tracks the fill state of each bank (bit 12 of the buffer address).
- Starts a tile when a source bank is full and a destination bank is free, then drives the read stream (exec/ia) and the result writes (outr/oa).
- On tile completion, hands the banks back to the loader and drainer.

Parameters:
- AW, 12, in-bank address width; bank select is bit AW.
- OUT_LAT, 2, cycles from the last exec of an output to its outr pulse (MAC pipeline depth, ≥1).
- TW, 8, width of the tile counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  one-cycle pulse; latch config and start a layer.
- in_num  in  AW+1  inputs per output, 1..4096.
- out_num  in  AW+1  outputs per tile, 1..4096.
- tiles  in  TW  tiles per layer, 1..255; 0 is treated as 1.
- fill_done  in  1  pulse: loader finished writing a source bank.
- fill_bank  in  1  bank for fill_done.
- drain_done  in  1  pulse: drainer finished reading a destination bank.
- drain_bank  in  1  bank for drain_done.
- exec  out  1  source read enable.
- ia  out  AW+1  source read address {bank, index}.
- clr  out  1  accumulator clear; coincides with the first exec of each output.
- outr  out  1  destination write request.
- oa  out  AW+1  destination address {bank, output index}.
- src_full  out  2  per-bank source-full flags.
- dst_full  out  2  per-bank destination-full flags.
- busy  out  1  layer in progress.
- done  out  1  one-cycle pulse at layer end.

Behaviour:
- Reset: all outputs 0. FSM in IDLE. sbank=dbank=0. All counters 0.
- States:
  - IDLE: run → WAIT; latch in_num, out_num, tiles; busy=1.
  - WAIT: src_full[sbank] & ~dst_full[dbank] → EXEC.
  - EXEC: one exec per cycle, ia={sbank, i}, i=0..in_num-1.
    - clr=1 when i==0.
    - After i==in_num-1: o<out_num-1 → o++, i=0, stay EXEC (back-to-back, no bubble); else → FLUSH.
  - FLUSH: wait until all outr pulses are issued (OUT_LAT cycles), then:
    - clear src_full[sbank]; set dst_full[dbank]; toggle sbank and dbank.
    - tile++; if tile==tiles → IDLE with done=1, busy=0; else → WAIT.
- outr pipeline: a delay line of depth OUT_LAT carries (last-exec flag, o).
  - outr=1 and oa={dbank, o} exactly OUT_LAT cycles after the exec with i==in_num-1.
  - At most one outr per cycle. Output spacing is ≥ in_num cycles, so there is no overlap.
- in_num==1: every exec has clr=1 and produces an outr.
- Flag updates:
  - fill_done sets src_full[fill_bank]; drain_done clears dst_full[drain_bank].
  - Same cycle as a scheduler update to the same bit: the external event wins for fill_done (set); the scheduler's set wins over drain_done on dst.
  - fill_done to an already-full bank: no effect.
- exec is never asserted to a bank whose src_full=0.
- outr is never asserted to a bank whose dst_full=1 at tile start.
- run while busy: ignored.
- Config changes are ignored after latch.
- Reset mid-operation clears everything, including in-flight outr; buffer contents are not touched.

Test Plan:
- Single tile, in_num=3, out_num=2, OUT_LAT=2. After fill_done(bank0) then run:
  - exec for 6 cycles, ia=0,1,2,0,1,2; clr on cycles 1 and 4.
  - outr 2 cycles after ia=2, with oa=0x000 then 0x001.
  - done one cycle after FLUSH; src_full=00, dst_full=01.
- Ping-pong, tiles=3, both banks prefilled:
  - tile 0 reads bank0 and writes bank0; tile 1 reads bank1 (ia[12]=1) and writes oa[12]=1.
  - Tile 2 stalls in WAIT until drain_done(bank0) and fill_done(bank0).
- Stall: run with no fill_done → exec stays 0 for 100 cycles; fill_done(bank0) → exec rises 2 cycles later.
- in_num=1, out_num=4: exec on 4 consecutive cycles, clr every cycle, outr on 4 consecutive cycles, oa=0..3.
- Simultaneous events: drain_done(bank0) in the same cycle as FLUSH sets dst_full[0] → dst_full[0]=1.
- Reset in EXEC mid-tile: all outputs 0 next cycle; no outr follows; a new run works normally.

Source files
------------

// File: rtl/buf_sched.sv
// buf_sched: ping-pong buffer scheduler around the MAC core.
// Tracks source/destination bank fill state, streams the source reads
// (exec/ia/clr) for each tile and issues the delayed result writes
// (outr/oa). Completed tiles hand the banks back to the loader/drainer.
//
// Handshake: fill_done/drain_done and run are single-cycle pulses sampled
// on the rising clock edge; there is no back-pressure on exec or outr.
module buf_sched #(
    parameter int AW      = 12,
    parameter int OUT_LAT = 2,
    parameter int TW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic [AW:0]   in_num,
    input  logic [AW:0]   out_num,
    input  logic [TW-1:0] tiles,
    input  logic          fill_done,
    input  logic          fill_bank,
    input  logic          drain_done,
    input  logic          drain_bank,
    output logic          exec,
    output logic [AW:0]   ia,
    output logic          clr,
    output logic          outr,
    output logic [AW:0]   oa,
    output logic [1:0]    src_full,
    output logic [1:0]    dst_full,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    localparam int FW = (OUT_LAT > 1) ? $clog2(OUT_LAT) : 1;
    localparam logic [AW:0]   ONE_A    = (AW+1)'(1);
    localparam logic [TW-1:0] TILE_ONE = TW'(1);
    localparam logic [FW-1:0] FL_ONE   = FW'(1);
    localparam logic [FW-1:0] FL_LAST  = FW'(OUT_LAT - 1);

    state_e        state_q, state_d;
    logic [AW:0]   in_num_q, in_num_d;
    logic [AW:0]   out_num_q, out_num_d;
    logic [TW-1:0] tiles_q, tiles_d;
    logic [AW:0]   i_q, i_d;
    logic [AW:0]   o_q, o_d;
    logic [TW-1:0] tile_q, tile_d;
    logic [FW-1:0] fl_q, fl_d;
    logic          sbank_q, sbank_d;
    logic          dbank_q, dbank_d;
    logic [1:0]    src_full_q, src_full_d;
    logic [1:0]    dst_full_q, dst_full_d;
    logic          done_q, done_d;

    // Result delay line: valid = last exec of an output, payload = output index.
    logic          pv_q [OUT_LAT];
    logic [AW-1:0] po_q [OUT_LAT];

    logic          exec_c;
    logic          clr_c;
    logic          last_c;
    logic          sched_rel;
    logic          last_i;
    logic          last_o;
    logic [TW-1:0] tile_inc;

    assign last_i   = (i_q == in_num_q - ONE_A);
    assign last_o   = (o_q == out_num_q - ONE_A);
    assign tile_inc = tile_q + TILE_ONE;

    // Next-state and stream control for the tile sequencer.
    always_comb begin
        state_d   = state_q;
        in_num_d  = in_num_q;
        out_num_d = out_num_q;
        tiles_d   = tiles_q;
        i_d       = i_q;
        o_d       = o_q;
        tile_d    = tile_q;
        fl_d      = fl_q;
        sbank_d   = sbank_q;
        dbank_d   = dbank_q;
        done_d    = 1'b0;
        sched_rel = 1'b0;
        exec_c    = 1'b0;
        clr_c     = 1'b0;
        last_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d   = S_WAIT;
                    in_num_d  = in_num;
                    out_num_d = out_num;
                    tiles_d   = (tiles == '0) ? TILE_ONE : tiles;
                    tile_d    = '0;
                    i_d       = '0;
                    o_d       = '0;
                end
            end
            S_WAIT: begin
                if (src_full_q[sbank_q] && !dst_full_q[dbank_q]) begin
                    state_d = S_EXEC;
                    i_d     = '0;
                    o_d     = '0;
                end
            end
            S_EXEC: begin
                exec_c = 1'b1;
                clr_c  = (i_q == '0);
                if (last_i) begin
                    last_c = 1'b1;
                    i_d    = '0;
                    if (last_o) begin
                        state_d = S_FLUSH;
                        fl_d    = '0;
                    end else begin
                        o_d = o_q + ONE_A;
                    end
                end else begin
                    i_d = i_q + ONE_A;
                end
            end
            S_FLUSH: begin
                // The last outr of the tile issues in the final FLUSH cycle,
                // so the banks are released on the edge that ends it.
                if (fl_q == FL_LAST) begin
                    sched_rel = 1'b1;
                    sbank_d   = ~sbank_q;
                    dbank_d   = ~dbank_q;
                    tile_d    = tile_inc;
                    if (tile_inc == tiles_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    fl_d = fl_q + FL_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bank flag merge: fill wins over the scheduler's clear, the scheduler's set wins over drain.
    always_comb begin
        src_full_d = src_full_q;
        dst_full_d = dst_full_q;
        if (sched_rel) src_full_d[sbank_q] = 1'b0;
        if (fill_done) src_full_d[fill_bank] = 1'b1;
        if (drain_done) dst_full_d[drain_bank] = 1'b0;
        if (sched_rel) dst_full_d[dbank_q] = 1'b1;
    end

    // Sequencer, configuration and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_num_q   <= '0;
            out_num_q  <= '0;
            tiles_q    <= '0;
            i_q        <= '0;
            o_q        <= '0;
            tile_q     <= '0;
            fl_q       <= '0;
            sbank_q    <= 1'b0;
            dbank_q    <= 1'b0;
            src_full_q <= '0;
            dst_full_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_num_q   <= in_num_d;
            out_num_q  <= out_num_d;
            tiles_q    <= tiles_d;
            i_q        <= i_d;
            o_q        <= o_d;
            tile_q     <= tile_d;
            fl_q       <= fl_d;
            sbank_q    <= sbank_d;
            dbank_q    <= dbank_d;
            src_full_q <= src_full_d;
            dst_full_q <= dst_full_d;
            done_q     <= done_d;
        end
    end

    // MAC-latency delay line from the last exec of an output to its outr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < OUT_LAT; k++) begin
                pv_q[k] <= 1'b0;
                po_q[k] <= '0;
            end
        end else begin
            pv_q[0] <= last_c;
            po_q[0] <= o_q[AW-1:0];
            for (int k = 1; k < OUT_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                po_q[k] <= po_q[k-1];
            end
        end
    end

    assign exec      = exec_c;
    assign clr       = clr_c;
    assign ia        = exec_c ? {sbank_q, i_q[AW-1:0]} : '0;
    assign outr      = pv_q[OUT_LAT-1];
    assign oa        = pv_q[OUT_LAT-1] ? {dbank_q, po_q[OUT_LAT-1]} : '0;
    assign src_full  = src_full_q;
    assign dst_full  = dst_full_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_buf_sched.sv
// tb_buf_sched: self-checking bench for buf_sched. A cycle-level reference
// derives each tile's exec/outr schedule in closed form from the tile start
// cycle, and tracks the bank flags from the pulses the bench drives.
module tb_buf_sched;

    localparam int AW = 12;
    localparam int OL = 2;
    localparam int TW = 8;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic [AW:0]   in_num;
    logic [AW:0]   out_num;
    logic [TW-1:0] tiles;
    logic          fill_done;
    logic          fill_bank;
    logic          drain_done;
    logic          drain_bank;
    logic          exec;
    logic [AW:0]   ia;
    logic          clr;
    logic          outr;
    logic [AW:0]   oa;
    logic [1:0]    src_full;
    logic [1:0]    dst_full;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;

    buf_sched #(.AW(AW), .OUT_LAT(OL), .TW(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .in_num     (in_num),
        .out_num    (out_num),
        .tiles      (tiles),
        .fill_done  (fill_done),
        .fill_bank  (fill_bank),
        .drain_done (drain_done),
        .drain_bank (drain_bank),
        .exec       (exec),
        .ia         (ia),
        .clr        (clr),
        .outr       (outr),
        .oa         (oa),
        .src_full   (src_full),
        .dst_full   (dst_full),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [AW:0] exp_q[$];
    logic [AW:0] log_ia[$];
    logic [AW:0] log_oa[$];

    // Reference model: layer config, bank pointers, flags, tile start cycle.
    int         m_busy, m_done, m_in, m_out, m_tiles, m_tile, m_sb, m_db, m_t0;
    logic [1:0] m_src, m_dst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_in = 1; m_out = 1; m_tiles = 1; m_tile = 0;
        m_sb = 0; m_db = 0; m_t0 = -1; m_src = 2'b00; m_dst = 2'b00;
    endtask

    // The tile's last outr lands OUT_LAT cycles after its last exec; the
    // banks are handed back on the edge that ends that cycle.
    function automatic bit model_tile_end();
        return (m_t0 >= 0) && (cyc == m_t0 + m_in * m_out - 1 + OL);
    endfunction

    // Compare every DUT output for the current cycle against the model.
    task automatic check_cycle();
        int k, d, e_ia, e_oa;
        bit e_exec, e_clr, e_outr;
        e_exec = 0; e_clr = 0; e_outr = 0; e_ia = 0; e_oa = 0;
        if (m_t0 >= 0) begin
            k = cyc - m_t0;
            if (k >= 0 && k < m_in * m_out) begin
                e_exec = 1;
                e_ia   = m_sb * 4096 + (k % m_in);
                e_clr  = ((k % m_in) == 0);
            end
            d = cyc - m_t0 - OL + 1;
            if (d > 0 && (d % m_in) == 0 && (d / m_in) <= m_out) begin
                e_outr = 1;
                e_oa   = m_db * 4096 + d / m_in - 1;
            end
        end
        check("exec", 32'(exec), 32'(e_exec));
        check("clr", 32'(clr), 32'(e_clr));
        if (e_exec) check("ia", 32'(ia), 32'(e_ia));
        check("outr", 32'(outr), 32'(e_outr));
        if (e_outr) check("oa", 32'(oa), 32'(e_oa));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("src_full", 32'(src_full), 32'(m_src));
        check("dst_full", 32'(dst_full), 32'(m_dst));
        if (exec) log_ia.push_back(ia);
        if (outr) log_oa.push_back(oa);
    endtask

    // Advance the model across the coming rising edge with these inputs.
    task automatic model_edge(input bit r, input int inn, input int outn, input int tl,
                              input bit fd, input bit fb, input bit dd, input bit db);
        bit         tile_end, start;
        int         old_busy;
        logic [1:0] ns, nd;
        old_busy = m_busy;
        tile_end = model_tile_end();
        start    = (m_busy != 0) && (m_t0 < 0) && m_src[m_sb] && !m_dst[m_db];
        ns = m_src;
        nd = m_dst;
        if (tile_end) ns[m_sb] = 1'b0;
        if (fd) ns[fb] = 1'b1;
        if (dd) nd[db] = 1'b0;
        if (tile_end) nd[m_db] = 1'b1;
        m_done = 0;
        if (start) m_t0 = cyc + 1;
        if (tile_end) begin
            m_sb   = 1 - m_sb;
            m_db   = 1 - m_db;
            m_tile = m_tile + 1;
            m_t0   = -1;
            if (m_tile == m_tiles) begin
                m_busy = 0;
                m_done = 1;
            end
        end
        if (old_busy == 0 && r) begin
            m_busy  = 1;
            m_in    = inn;
            m_out   = outn;
            m_tiles = (tl == 0) ? 1 : tl;
            m_tile  = 0;
            m_t0    = -1;
        end
        m_src = ns;
        m_dst = nd;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit r, input int inn, input int outn, input int tl,
                        input bit fd, input bit fb, input bit dd, input bit db);
        check_cycle();
        run        = r;
        in_num     = 13'(inn);
        out_num    = 13'(outn);
        tiles      = 8'(tl);
        fill_done  = fd;
        fill_bank  = fb;
        drain_done = dd;
        drain_bank = db;
        model_edge(r, inn, outn, tl, fd, fb, dd, db);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill(input bit b);
        step(0, 0, 0, 0, 1, b, 0, 0);
    endtask

    task automatic drain(input bit b);
        step(0, 0, 0, 0, 0, 0, 1, b);
    endtask

    task automatic start_layer(input int inn, input int outn, input int tl);
        step(1, inn, outn, tl, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        run = 0; fill_done = 0; drain_done = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_cycle();
        check("rst_exec", 32'(exec), 32'd0);
        check("rst_outr", 32'(outr), 32'd0);
        @(negedge clk);
        cyc++;
        check_cycle();
        rst_n = 1'b1;
    endtask

    // Compare the logged stream against the expected queue, in order.
    task automatic check_log(input string tag, input bit use_oa);
        int n;
        n = use_oa ? log_oa.size() : log_ia.size();
        check({tag, "_len"}, 32'(n), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            logic [AW:0] e, o;
            e = exp_q.pop_front();
            o = 'x;
            if (use_oa) begin
                if (log_oa.size() > 0) o = log_oa.pop_front();
            end else begin
                if (log_ia.size() > 0) o = log_ia.pop_front();
            end
            check(tag, 32'(o), 32'(e));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        int pre_checks;
        rst_n = 1'b0; run = 0; in_num = '0; out_num = '0; tiles = '0;
        fill_done = 0; fill_bank = 0; drain_done = 0; drain_bank = 0;
        model_reset();
        @(negedge clk);
        cyc++;
        check_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        cyc++;

        // Single tile, 3 inputs x 2 outputs.
        fill(0);
        log_ia.delete(); log_oa.delete();
        start_layer(3, 2, 1);
        idle(14);
        exp_q = '{13'h000, 13'h001, 13'h002, 13'h000, 13'h001, 13'h002};
        check_log("t1_ia", 0);
        exp_q = '{13'h000, 13'h001};
        check_log("t1_oa", 1);
        check("t1_src", 32'(src_full), 32'd0);
        check("t1_dst", 32'(dst_full), 32'd1);

        // Ping-pong over three tiles, drain coinciding with the bank hand-back.
        do_reset();
        fill(0);
        fill(1);
        start_layer(2, 2, 3);
        found = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            if (model_tile_end() && m_db == 0) begin
                found = 1;
                drain(0);
            end else begin
                idle(1);
            end
        end
        check("simul_found", 32'(found), 32'd1);
        check("simul_dst0", 32'(dst_full[0]), 32'd1);
        idle(40);
        check("pp_stall_busy", 32'(busy), 32'd1);
        check("pp_stall_exec", 32'(exec), 32'd0);
        drain(0);
        fill(0);
        idle(25);
        check("pp_end_busy", 32'(busy), 32'd0);

        // Stall without source data, then release.
        do_reset();
        start_layer(2, 2, 1);
        log_ia.delete();
        idle(100);
        check("stall_no_exec", 32'(log_ia.size()), 32'd0);
        fill(0);
        check("stall_exec_1", 32'(exec), 32'd0);
        idle(1);
        check("stall_exec_2", 32'(exec), 32'd1);
        idle(15);

        // One input per output: clr on every exec, outr back to back.
        do_reset();
        fill(0);
        log_ia.delete(); log_oa.delete();
        start_layer(1, 4, 1);
        idle(12);
        exp_q = '{13'h000, 13'h000, 13'h000, 13'h000};
        check_log("t4_ia", 0);
        exp_q = '{13'h000, 13'h001, 13'h002, 13'h003};
        check_log("t4_oa", 1);

        // Reset in the middle of a tile, then a clean layer.
        do_reset();
        fill(0);
        start_layer(4, 3, 1);
        idle(6);
        check("mid_exec_active", 32'(exec), 32'd1);
        do_reset();
        log_oa.delete();
        idle(10);
        check("post_rst_no_outr", 32'(log_oa.size()), 32'd0);
        fill(0);
        start_layer(2, 2, 1);
        idle(15);
        check("post_rst_dst", 32'(dst_full), 32'd1);

        // Randomized traffic: random pulses, runs (also while busy) and config churn.
        do_reset();
        pre_checks = n_checks;
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 19) == 0,
                 $urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(0, 3),
                 $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
        end
        check("rand_ran", 32'(n_checks > pre_checks), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
